// File: rtl/ram_port_seq.sv
// ram_port_seq: turns single-operand write/read commands with W-bit chunk streams into RAM port cycles.
// Define RAM_SEQ_VERIFY_EN to add a post-write read-back compare that raises a sticky verify_err.
module ram_port_seq #(
  parameter int unsigned DATA = 198,
  parameter int unsigned ADDR = 7,
  parameter int unsigned W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [W-1:0]    wdata,
  output logic            rdata_valid,
  input  logic            rdata_ready,
  output logic [W-1:0]    rdata,
  output logic            busy,
  output logic            verify_err,
  output logic            ram_wr,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  localparam int unsigned N  = (DATA + W - 1) / W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = (DATA > 1) ? $clog2(DATA) : 1;
  localparam int unsigned WW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    WCOLLECT,
    WCOMMIT,
    RISSUE,
    RCAPTURE,
    RSEND
`ifdef RAM_SEQ_VERIFY_EN
    ,
    WVERIFY,
    WCHECK
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] addr_q;
  logic [CW-1:0]   cnt_q;
  logic [DATA-1:0] buf_q;

  // Chunk sel of an operand; bits at or above DATA read as zero.
  function automatic logic [W-1:0] chunk_of(input logic [DATA-1:0] v, input logic [CW-1:0] sel);
    logic [W-1:0] c;
    c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (CW'(k) == sel) begin
        for (int j = 0; j < int'(W); j++) begin
          if (k * int'(W) + j < int'(DATA)) c[WW'(j)] = v[DW'(k * int'(W) + j)];
        end
      end
    end
    return c;
  endfunction

  // Overwrite chunk sel of an operand; chunk bits beyond DATA are dropped.
  function automatic logic [DATA-1:0] fill(input logic [DATA-1:0] v, input logic [CW-1:0] sel,
                                           input logic [W-1:0] d);
    logic [DATA-1:0] r;
    r = v;
    for (int b = 0; b < int'(DATA); b++) begin
      if (CW'(b / int'(W)) == sel) r[DW'(b)] = d[WW'(b % int'(W))];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_wr      = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_wr ? WCOLLECT : RISSUE;
      end
      WCOLLECT: begin
        wdata_ready = 1'b1;
        if (wdata_valid && (cnt_q == LAST)) state_d = WCOMMIT;
      end
      WCOMMIT: begin
        ram_wr = 1'b1;
`ifdef RAM_SEQ_VERIFY_EN
        state_d = WVERIFY;
`else
        state_d = IDLE;
`endif
      end
`ifdef RAM_SEQ_VERIFY_EN
      WVERIFY: state_d = WCHECK;
      WCHECK:  state_d = IDLE;
`endif
      RISSUE:   state_d = RCAPTURE;
      RCAPTURE: state_d = RSEND;
      RSEND: begin
        if (rdata_valid && rdata_ready && (cnt_q == LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, chunk counter, operand buffer and registered read stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= '0;
          end
        end
        WCOLLECT: begin
          if (wdata_valid) begin
            buf_q <= fill(buf_q, cnt_q, wdata);
            if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
          end
        end
        RCAPTURE: begin
          buf_q       <= ram_dout;
          cnt_q       <= '0;
          rdata       <= chunk_of(ram_dout, '0);
          rdata_valid <= 1'b1;
        end
        RSEND: begin
          if (rdata_valid && rdata_ready) begin
            if (cnt_q == LAST) begin
              rdata_valid <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              rdata <= chunk_of(buf_q, cnt_q + CW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_SEQ_VERIFY_EN
  // Read-back differs from what was committed: the other port hit the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     verify_err <= 1'b0;
    else if ((state_q == WCHECK) && (ram_dout != buf_q)) verify_err <= 1'b1;
  end
`else
  assign verify_err = 1'b0;
`endif

  assign ram_addr = addr_q;
  assign ram_din  = buf_q;

endmodule

// File: tb/tb_ram_port_seq.sv
// Self-checking bench for ram_port_seq: dual-port RAM model, shadow memory reference, directed + random steps.
module tb_ram_port_seq;
  localparam int DATA = 198;
  localparam int ADDR = 7;
  localparam int W    = 32;
  localparam int N    = (DATA + W - 1) / W;
  localparam int PADW = N * W;
  localparam int DEPTH = 1 << ADDR;
`ifdef RAM_SEQ_VERIFY_EN
  localparam int IDLE_RET = N + 4;
  localparam logic VERIFY = 1'b1;
`else
  localparam int IDLE_RET = N + 2;
  localparam logic VERIFY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR-1:0] cmd_addr;
  logic            wdata_valid, wdata_ready;
  logic [W-1:0]    wdata;
  logic            rdata_valid, rdata_ready;
  logic [W-1:0]    rdata;
  logic            busy, verify_err, ram_wr;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din, ram_dout;

  ram_port_seq #(.DATA(DATA), .ADDR(ADDR), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .verify_err(verify_err),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand RAM: registered read (old data on collision); other port may overwrite in the same cycle.
  logic [DATA-1:0] mem [DEPTH];
  logic            inject_en = 1'b0;
  logic [ADDR-1:0] inject_addr = '0;
  logic [DATA-1:0] inject_val = '0;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (inject_en && ram_wr && (ram_addr == inject_addr)) mem[inject_addr] <= inject_val;
    ram_dout <= mem[ram_addr];
  end

  int              wr_pulses = 0;
  int              overlap = 0;
  int              last_wr_cyc = 0;
  logic [ADDR-1:0] last_wr_addr = '0;
  logic [DATA-1:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (ram_wr) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_cyc  <= cyc;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_din;
    end
    if (ram_wr && rdata_valid) overlap <= overlap + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: shadow memory plus chunk packing by plain shifts.
  logic [DATA-1:0] exp_mem [DEPTH];
  logic [W-1:0]    wch [N];

  function automatic logic [DATA-1:0] pack_wch();
    logic [PADW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p = p | (PADW'(wch[k]) << (k * W));
    return DATA'(p);
  endfunction

  function automatic logic [W-1:0] exp_chunk(input logic [DATA-1:0] v, input int k);
    logic [PADW-1:0] p;
    p = PADW'(v);
    return W'(p >> (k * W));
  endfunction

  task automatic issue_cmd(input logic wr, input logic [ADDR-1:0] a, input bit keep, output int tacc);
    int guard;
    guard = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept", DATA'(cmd_ready), DATA'(1));
    tacc = cyc;
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic send_chunks(input int count, input bit stall);
    int k, guard;
    k = 0; guard = 0;
    while (k < count && guard < 500) begin
      wdata_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata = wch[k];
      @(negedge clk);
      if (wdata_valid && wdata_ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    wdata_valid = 1'b0;
    chk("wdata_accepted", DATA'(k), DATA'(count));
  endtask

  task automatic wait_idle(output int tidle);
    int guard;
    guard = 0;
    tidle = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("return_idle", DATA'(cmd_ready), DATA'(1));
    tidle = cyc;
    @(posedge clk); #1;
  endtask

  task automatic recv_chunks(input logic [DATA-1:0] expv, input bit stall, input int tacc,
                             input bit chk_busy, output int t_last);
    int k, guard;
    bit first, held;
    logic [W-1:0] prev;
    k = 0; guard = 0; first = 1'b1; held = 1'b0; prev = '0; t_last = 0;
    while (k < N && guard < 500) begin
      rdata_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (chk_busy) chk("cmd_ready_busy", DATA'(cmd_ready), DATA'(0));
      if (held) begin
        chk("rdata_stable", DATA'(rdata), DATA'(prev));
        chk("rdata_valid_held", DATA'(rdata_valid), DATA'(1));
      end
      held = 1'b0;
      if (rdata_valid) begin
        if (first) begin
          chk("first_rvalid_latency", DATA'(cyc - tacc), DATA'(3));
          first = 1'b0;
        end
        if (rdata_ready) begin
          chk($sformatf("rdata_chunk%0d", k), DATA'(rdata), DATA'(exp_chunk(expv, k)));
          k++;
          t_last = cyc;
        end else begin
          held = 1'b1;
          prev = rdata;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    rdata_ready = 1'b0;
    chk("rdata_received", DATA'(k), DATA'(N));
  endtask

  task automatic write_op(input logic [ADDR-1:0] a, input bit stall, output int tacc, output int tidle);
    int p0;
    logic [DATA-1:0] d;
    p0 = wr_pulses;
    d = pack_wch();
    issue_cmd(1'b1, a, 1'b0, tacc);
    send_chunks(N, stall);
    wait_idle(tidle);
    chk("wr_pulse_count", DATA'(wr_pulses - p0), DATA'(1));
    chk("ram_wr_addr", DATA'(last_wr_addr), DATA'(a));
    chk("ram_wr_data", last_wr_data, d);
    exp_mem[a] = d;
  endtask

  task automatic read_op(input logic [ADDR-1:0] a, input bit stall);
    int tacc, tl;
    issue_cmd(1'b0, a, 1'b0, tacc);
    recv_chunks(exp_mem[a], stall, tacc, 1'b0, tl);
  endtask

  task automatic reset_value_checks(input string pfx);
    chk({pfx, "_cmd_ready"}, DATA'(cmd_ready), DATA'(1));
    chk({pfx, "_wdata_ready"}, DATA'(wdata_ready), DATA'(0));
    chk({pfx, "_rdata_valid"}, DATA'(rdata_valid), DATA'(0));
    chk({pfx, "_rdata"}, DATA'(rdata), DATA'(0));
    chk({pfx, "_busy"}, DATA'(busy), DATA'(0));
    chk({pfx, "_verify_err"}, DATA'(verify_err), DATA'(0));
    chk({pfx, "_ram_wr"}, DATA'(ram_wr), DATA'(0));
    chk({pfx, "_ram_addr"}, DATA'(ram_addr), DATA'(0));
    chk({pfx, "_ram_din"}, ram_din, DATA'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tacc, tidle, tl, p0;
  logic [DATA-1:0] d9;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_value_checks("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read of an untouched address right after reset returns zeros.
    read_op(7'd127, 1'b0);

    // Directed write of chunks 1..7 to addr 5, with exact no-stall timing.
    for (int k = 0; k < N; k++) wch[k] = W'(k + 1);
    write_op(7'd5, 1'b0, tacc, tidle);
    chk("ram_wr_cycle", DATA'(last_wr_cyc - tacc), DATA'(N + 1));
    chk("idle_return_cycle", DATA'(tidle - tacc), DATA'(IDLE_RET));
    chk("verify_err_clean", DATA'(verify_err), DATA'(0));
    read_op(7'd5, 1'b0);

    // Stalled write then read at 0x40 with random data (including junk above DATA).
    for (int k = 0; k < N; k++) wch[k] = $urandom();
    write_op(7'h40, 1'b1, tacc, tidle);
    read_op(7'h40, 1'b1);

    // A few random addresses, random stalls.
    for (int r = 0; r < 4; r++) begin
      logic [ADDR-1:0] a;
      a = ADDR'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < N; k++) wch[k] = $urandom();
      write_op(a, 1'($urandom_range(0, 1)), tacc, tidle);
      read_op(a, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a write to addr 9 must leave the RAM untouched.
    for (int k = 0; k < N; k++) wch[k] = $urandom();
    write_op(7'd9, 1'b0, tacc, tidle);
    d9 = exp_mem[9];
    p0 = wr_pulses;
    for (int k = 0; k < N; k++) wch[k] = ~wch[k];
    issue_cmd(1'b1, 7'd9, 1'b0, tacc);
    send_chunks(4, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_value_checks("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_wr", DATA'(wr_pulses), DATA'(p0));
    @(posedge clk); #1;
    chk("midrst_model_kept", exp_mem[9], d9);
    read_op(7'd9, 1'b0);

    // cmd_valid held through a read: the next command waits for cmd_ready.
    issue_cmd(1'b0, 7'd5, 1'b1, tacc);
    cmd_wr = 1'b1; cmd_addr = 7'd20;
    recv_chunks(exp_mem[5], 1'b1, tacc, 1'b1, tl);
    for (int k = 0; k < N; k++) wch[k] = $urandom();
    p0 = wr_pulses;
    issue_cmd(1'b1, 7'd20, 1'b0, tacc);
    chk("held_cmd_accept", DATA'(tacc - tl), DATA'(1));
    send_chunks(N, 1'b0);
    wait_idle(tidle);
    chk("held_wr_pulse", DATA'(wr_pulses - p0), DATA'(1));
    exp_mem[20] = pack_wch();
    read_op(7'd20, 1'b0);

    // Other port overwrites addr 3 in the commit cycle.
    inject_en = 1'b1; inject_addr = 7'd3; inject_val = DATA'(12'hABC);
    for (int k = 0; k < N; k++) wch[k] = $urandom();
    write_op(7'd3, 1'b0, tacc, tidle);
    inject_en = 1'b0;
    exp_mem[3] = DATA'(12'hABC);
    chk("verify_err_collision", DATA'(verify_err), DATA'(VERIFY));
    for (int k = 0; k < N; k++) wch[k] = $urandom();
    write_op(7'd10, 1'b0, tacc, tidle);
    chk("verify_err_sticky", DATA'(verify_err), DATA'(VERIFY));
    read_op(7'd3, 1'b0);

    @(negedge clk);
    chk("no_wr_rsend_overlap", DATA'(overlap), DATA'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_seq.md
# ram_port_seq

Sequencer that sits between a narrow host/controller stream and one port of the shared dual-port operand RAM. It turns a single-word command (write or read one DATA-bit operand at an address) into the RAM port signals. Write data arrives as W-bit chunks; read data leaves as W-bit chunks. It accounts for the RAM's one-cycle registered read latency, so operand loading and unloading of the pairing core needs no glue logic.

## Interface
- DATA, 198: operand width, equal to the RAM word width
- ADDR, 7: RAM address width
- W, 32: stream chunk width; N = ceil(DATA/W) chunks per operand (7 at defaults)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_wr  in  1  1 = write operand, 0 = read operand
- cmd_addr  in  ADDR  target RAM address
- wdata_valid / wdata_ready  in / out  1  write-chunk handshake
- wdata  in  W  write chunk
- rdata_valid / rdata_ready  out / in  1  read-chunk handshake
- rdata  out  W  read chunk
- busy  out  1  high whenever state is not IDLE
- verify_err  out  1  sticky write-verify mismatch (see Configuration)
- ram_wr  out  1  RAM port write enable
- ram_addr  out  ADDR  RAM port address
- ram_din  out  DATA  RAM port write data
- ram_dout  in  DATA  RAM port registered read data

## Operation
- States: IDLE, WCOLLECT, WCOMMIT, WVERIFY, WCHECK, RISSUE, RCAPTURE, RSEND.
- IDLE: cmd_ready=1. On accept, latch cmd_addr into the address register and clear the chunk counter. If cmd_wr=1, go to WCOLLECT; otherwise go to RISSUE.
- ram_addr always equals the latched address register.
- WCOLLECT: wdata_ready=1. Chunk k fills bits [k*W +: W] of the DATA-bit buffer, with chunk 0 least significant. Bits of the last chunk at or above DATA are discarded. After chunk N-1 is accepted, go to WCOMMIT.
- WCOMMIT: ram_wr=1 and ram_din=buffer for exactly one cycle. Next state is WVERIFY if the macro is defined, otherwise IDLE.
- RISSUE: one cycle with the address presented, ram_wr=0.
- RCAPTURE: buffer <= ram_dout. Go to RSEND.
- RSEND: rdata_valid=1 and rdata = buffer chunk k. Bits at or above DATA read as 0. The counter advances on each handshake. After chunk N-1 is accepted, go to IDLE.
- The chunk counter is clog2(N) bits wide. It never wraps within an operand and resets to 0 on each command.
- ram_din is driven from the buffer at all times; only ram_wr qualifies it.
- No command is accepted while busy. cmd_valid held during busy simply waits.

## Timing
- Reset values: state IDLE, cmd_ready=1, wdata_ready=0, rdata_valid=0, rdata=0, busy=0, verify_err=0, ram_wr=0, ram_addr=0, buffer=0, counter=0.
- Reset asserted mid-operation aborts immediately. No partial write ever reaches the RAM, because ram_wr is asserted only in WCOMMIT.
- Write, no stalls: command accepted at cycle t, chunks accepted at t+1..t+N, ram_wr high at t+N+1. cmd_ready is high again at t+N+2 without the macro, or t+N+4 with it.
- Read, no stalls: command accepted at t, RISSUE at t+1, ram_dout sampled at the end of t+2, first rdata_valid at t+3, last chunk at t+N+2 if rdata_ready is held high.
- rdata and rdata_valid are registered. Once asserted, rdata_valid stays high with rdata stable until the handshake completes.
- wdata_ready and cmd_ready are decoded from the registered state.

## Configuration
- RAM_SEQ_VERIFY_EN defined:
  - WVERIFY holds the address for one cycle with ram_wr=0.
  - WCHECK compares ram_dout with the buffer. A mismatch sets verify_err, which stays set until rst_n.
  - This catches a concurrent write to the same address from the other RAM port.
- RAM_SEQ_VERIFY_EN undefined:
  - WVERIFY and WCHECK are absent; WCOMMIT goes directly to IDLE.
  - verify_err is tied to 0.

## Test plan
- Write addr 5 with chunks 0x00000001..0x00000007 (DATA=198), then read addr 5 -> rdata returns 0x00000001..0x00000006, then 0x00000007 & 0x3F; one ram_wr pulse with ram_addr=5.
- Read addr 127 after reset -> 7 chunks of 0; first rdata_valid exactly 3 cycles after cmd accept.
- Random wdata_valid and rdata_ready stalls (~50%) on a write then read of addr 0x40 -> data preserved, rdata stable while stalled, exactly one ram_wr pulse.
- Assert rst_n low after chunk 3 of a write to addr 9 -> ram_wr never asserted, outputs at reset values, a later read of addr 9 returns the prior contents.
- cmd_valid held high during a read transfer -> second command accepted only on the cycle cmd_ready returns high; no overlap of ram_wr with RSEND.
- RAM_SEQ_VERIFY_EN: the other port writes 0xABC to addr 3 in the WCOMMIT cycle -> verify_err=1 and sticky. Without the macro, the same stimulus -> verify_err=0.
